// File: rtl/pic_vec.sv
// Vectored interrupt controller: NUM_IRQ prioritised request lines, mask and
// in-service registers, EOI commands over two I/O ports and the two-cycle INTA vector.
module pic_vec #(
   parameter int          NUM_IRQ    = 8,
   parameter logic [7:0]  VEC_BASE   = 8'h08,
   parameter logic [15:0] IO_BASE    = 16'h0020,
   parameter logic [7:0]  TRIG_LEVEL = 8'h00,
   parameter logic [7:0]  IMR_RESET  = 8'hFF,
   parameter bit          AEOI       = 1'b0
) (
   input  logic               iClk,
   input  logic               iRst,
   input  logic [NUM_IRQ-1:0] iIrq,
   input  logic [15:0]        iAddr,
   input  logic [7:0]         iData,
   input  logic               iIoRd,
   input  logic               iIoWr,
   input  logic               iIntAck,
   output logic               oInt,
   output logic               oSel,
   output logic [7:0]         oData
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACK1  = 2'd1,
      S_WAIT2 = 2'd2,
      S_ACK2  = 2'd3
   } state_t;

   localparam logic [3:0] NONE     = 4'(NUM_IRQ);
   localparam logic [2:0] SPURIOUS = 3'd7;

   function automatic logic [3:0] lowest_set(input logic [NUM_IRQ-1:0] v);
      logic [3:0] idx;
      idx = NONE;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic [NUM_IRQ-1:0] onehot(input logic [3:0] idx);
      logic [NUM_IRQ-1:0] r;
      for (int i = 0; i < NUM_IRQ; i++) begin
         r[i] = (idx == 4'(i));
      end
      return r;
   endfunction

   function automatic logic [NUM_IRQ-1:0] below(input logic [3:0] lim);
      logic [NUM_IRQ-1:0] r;
      for (int i = 0; i < NUM_IRQ; i++) begin
         r[i] = (4'(i) < lim);
      end
      return r;
   endfunction

   function automatic logic [7:0] pad8(input logic [NUM_IRQ-1:0] v);
      logic [7:0] r;
      r = 8'h00;
      r[NUM_IRQ-1:0] = v;
      return r;
   endfunction

   state_t             state_q, state_d;
   logic [NUM_IRQ-1:0] irr_q, irr_d;
   logic [NUM_IRQ-1:0] isr_q, isr_d;
   logic [NUM_IRQ-1:0] imr_q, imr_d;
   logic [NUM_IRQ-1:0] irq_prev_q;
   logic               inta_prev_q;
   logic               iowr_prev_q;
   logic [2:0]         chan_q, chan_d;
   logic               ack_real_q, ack_real_d;
   logic               int_q, int_d;
   logic               sel_q, sel_d;
   logic [7:0]         data_q, data_d;

   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] allowed;
   logic [3:0]         win_idx;
   logic               has_win;
   logic               inta_rise;
   logic               wr_rise;
   logic               dec_cmd;
   logic               dec_mask;
   logic               ack_now;
   logic [NUM_IRQ-1:0] ack_clr;
   logic [NUM_IRQ-1:0] ack_set;
   logic [NUM_IRQ-1:0] eoi_clr;
   logic [NUM_IRQ-1:0] edge_set;
   logic [NUM_IRQ-1:0] frozen;

   // Priority resolution, bus decode and all next-state logic
   always_comb begin
      pending   = irr_q & ~imr_q;
      allowed   = below(lowest_set(isr_q));
      win_idx   = lowest_set(pending & allowed);
      has_win   = (win_idx != NONE);
      inta_rise = iIntAck & ~inta_prev_q;
      wr_rise   = iIoWr & ~iowr_prev_q;
      dec_cmd   = (iAddr == IO_BASE);
      dec_mask  = (iAddr == (IO_BASE + 16'd1));
      ack_now   = (state_q == S_IDLE) && inta_rise;

      state_d    = state_q;
      chan_d     = chan_q;
      ack_real_d = ack_real_q;
      case (state_q)
         S_IDLE: begin
            if (inta_rise) begin
               state_d = S_ACK1;
               if (has_win) begin
                  chan_d     = win_idx[2:0];
                  ack_real_d = 1'b1;
               end else begin
                  chan_d     = SPURIOUS;
                  ack_real_d = 1'b0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACK1: begin
            if (!iIntAck) begin
               state_d = S_WAIT2;
            end else begin
               state_d = S_ACK1;
            end
         end
         S_WAIT2: begin
            if (inta_rise) begin
               state_d = S_ACK2;
            end else begin
               state_d = S_WAIT2;
            end
         end
         S_ACK2: begin
            if (!iIntAck) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_ACK2;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The vector cycle owns the read bus over any concurrent port read
      if (((state_q == S_WAIT2) && inta_rise) || ((state_q == S_ACK2) && iIntAck)) begin
         sel_d  = 1'b1;
         data_d = VEC_BASE + {5'b00000, chan_q};
      end else if (iIoRd && dec_cmd) begin
         sel_d  = 1'b1;
         data_d = pad8(isr_q);
      end else if (iIoRd && dec_mask) begin
         sel_d  = 1'b1;
         data_d = pad8(imr_q);
      end else begin
         sel_d  = 1'b0;
         data_d = 8'h00;
      end

      int_d = (state_q == S_IDLE) && !inta_rise && has_win;

      if (ack_now && has_win) begin
         ack_clr = onehot(win_idx);
      end else begin
         ack_clr = '0;
      end
      if (AEOI) begin
         ack_set = '0;
      end else begin
         ack_set = ack_clr;
      end

      // Out-of-range channel numbers decode to an empty one-hot and are ignored
      eoi_clr = '0;
      if (wr_rise && dec_cmd) begin
         if (iData == 8'h20) begin
            eoi_clr = onehot(lowest_set(isr_q));
         end else if (iData[7:3] == 5'b01100) begin
            eoi_clr = onehot({1'b0, iData[2:0]});
         end else begin
            eoi_clr = '0;
         end
      end else begin
         eoi_clr = '0;
      end
      isr_d = (isr_q & ~eoi_clr) | ack_set;

      if (wr_rise && dec_mask) begin
         imr_d = iData[NUM_IRQ-1:0];
      end else begin
         imr_d = imr_q;
      end

      edge_set = iIrq & ~irq_prev_q;
      if ((state_q != S_IDLE) && ack_real_q) begin
         frozen = onehot({1'b0, chan_q});
      end else begin
         frozen = '0;
      end
      irr_d = irr_q;
      for (int n = 0; n < NUM_IRQ; n++) begin
         if (TRIG_LEVEL[n]) begin
            if (frozen[n]) begin
               irr_d[n] = irr_q[n];
            end else if (ack_clr[n]) begin
               irr_d[n] = 1'b0;
            end else begin
               irr_d[n] = iIrq[n];
            end
         end else begin
            irr_d[n] = edge_set[n] | (irr_q[n] & ~ack_clr[n]);
         end
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge iClk) begin
      if (!iRst) begin
         state_q     <= S_IDLE;
         irr_q       <= '0;
         isr_q       <= '0;
         imr_q       <= IMR_RESET[NUM_IRQ-1:0];
         irq_prev_q  <= '0;
         inta_prev_q <= 1'b0;
         iowr_prev_q <= 1'b0;
         chan_q      <= 3'd0;
         ack_real_q  <= 1'b0;
         int_q       <= 1'b0;
         sel_q       <= 1'b0;
         data_q      <= 8'h00;
      end else begin
         state_q     <= state_d;
         irr_q       <= irr_d;
         isr_q       <= isr_d;
         imr_q       <= imr_d;
         irq_prev_q  <= iIrq;
         inta_prev_q <= iIntAck;
         iowr_prev_q <= iIoWr;
         chan_q      <= chan_d;
         ack_real_q  <= ack_real_d;
         int_q       <= int_d;
         sel_q       <= sel_d;
         data_q      <= data_d;
      end
   end

   assign oInt  = int_q;
   assign oSel  = sel_q;
   assign oData = data_q;

endmodule

// File: tb/tb_pic_vec.sv
// Self-checking bench for pic_vec: directed scenarios plus randomized bus/IRQ
// traffic, all compared every cycle against a behavioural model.
module tb_pic_vec;

   localparam logic [7:0]  VB      = 8'h08;
   localparam logic [7:0]  TRIG    = 8'h10;
   localparam logic [7:0]  IMR_RST = 8'hFF;
   localparam bit          AEOI_P  = 1'b0;

   logic        iClk = 1'b0;
   logic        iRst = 1'b0;
   logic [7:0]  iIrq = 8'h00;
   logic [15:0] iAddr = 16'h0000;
   logic [7:0]  iData = 8'h00;
   logic        iIoRd = 1'b0;
   logic        iIoWr = 1'b0;
   logic        iIntAck = 1'b0;
   logic        oInt;
   logic        oSel;
   logic [7:0]  oData;

   pic_vec #(
      .NUM_IRQ(8), .VEC_BASE(VB), .IO_BASE(16'h0020),
      .TRIG_LEVEL(TRIG), .IMR_RESET(IMR_RST), .AEOI(AEOI_P)
   ) dut (
      .iClk(iClk), .iRst(iRst), .iIrq(iIrq), .iAddr(iAddr), .iData(iData),
      .iIoRd(iIoRd), .iIoWr(iIoWr), .iIntAck(iIntAck),
      .oInt(oInt), .oSel(oSel), .oData(oData)
   );

   always #5 iClk = ~iClk;

   // behavioural model state
   logic [7:0] m_irr, m_isr, m_imr, m_prev;
   bit         m_ack_prev, m_wr_prev, m_real;
   int         m_phase;   // 0 idle, 1 first INTA, 2 between, 3 second INTA
   int         m_chan;
   bit         e_int, e_sel;
   logic [7:0] e_data;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [7:0] n_irr, n_isr, n_imr, trig;
      int w, lim, acked, low, nch;
      bit rise, wrise, cmd, msk, edg;
      if (!iRst) begin
         m_irr = 8'h00; m_isr = 8'h00; m_imr = IMR_RST; m_prev = 8'h00;
         m_ack_prev = 1'b0; m_wr_prev = 1'b0; m_real = 1'b0;
         m_phase = 0; m_chan = 0;
         e_int = 1'b0; e_sel = 1'b0; e_data = 8'h00;
         return;
      end
      trig  = TRIG;
      rise  = iIntAck && !m_ack_prev;
      wrise = iIoWr && !m_wr_prev;
      cmd   = (iAddr == 16'h0020);
      msk   = (iAddr == 16'h0021);
      lim = 8;
      for (int i = 7; i >= 0; i--) if (m_isr[i]) lim = i;
      w = -1;
      for (int i = lim - 1; i >= 0; i--) if (m_irr[i] && !m_imr[i]) w = i;

      e_int = (m_phase == 0) && !rise && (w >= 0);
      if ((m_phase == 2 && rise) || (m_phase == 3 && iIntAck)) begin
         e_sel = 1'b1; e_data = VB + 8'(m_chan);
      end else if (iIoRd && cmd) begin
         e_sel = 1'b1; e_data = m_isr;
      end else if (iIoRd && msk) begin
         e_sel = 1'b1; e_data = m_imr;
      end else begin
         e_sel = 1'b0; e_data = 8'h00;
      end

      n_irr = m_irr; n_isr = m_isr; n_imr = m_imr;
      acked = -1;
      if (m_phase == 0 && rise) begin
         if (w >= 0) begin
            acked = w;
         end
      end

      if (wrise && msk) n_imr = iData;
      if (wrise && cmd) begin
         if (iData == 8'h20) begin
            low = -1;
            for (int i = 7; i >= 0; i--) if (m_isr[i]) low = i;
            if (low >= 0) n_isr[low] = 1'b0;
         end else if (iData[7:3] == 5'b01100) begin
            nch = int'(iData[2:0]);
            n_isr[nch] = 1'b0;
         end
      end
      if (acked >= 0 && !AEOI_P) n_isr[acked] = 1'b1;

      for (int i = 0; i < 8; i++) begin
         if (trig[i]) begin
            if (m_phase != 0 && m_real && m_chan == i) n_irr[i] = m_irr[i];
            else if (acked == i) n_irr[i] = 1'b0;
            else n_irr[i] = iIrq[i];
         end else begin
            edg = iIrq[i] && !m_prev[i];
            if (acked == i) n_irr[i] = 1'b0;
            if (edg) n_irr[i] = 1'b1;
         end
      end

      if (m_phase == 0 && rise) begin
         m_phase = 1;
         if (w >= 0) begin m_chan = w; m_real = 1'b1; end
         else begin m_chan = 7; m_real = 1'b0; end
      end else if (m_phase == 1 && !iIntAck) m_phase = 2;
      else if (m_phase == 2 && rise) m_phase = 3;
      else if (m_phase == 3 && !iIntAck) m_phase = 0;

      m_irr = n_irr; m_isr = n_isr; m_imr = n_imr;
      m_prev = iIrq; m_ack_prev = iIntAck; m_wr_prev = iIoWr;
   endtask

   task automatic tick();
      model_step();
      @(posedge iClk);
      #1;
      check("oInt", {7'd0, oInt}, {7'd0, e_int});
      check("oSel", {7'd0, oSel}, {7'd0, e_sel});
      if (e_sel) check("oData", oData, e_data);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse(input int b);
      iIrq[b] = 1'b1; tick();
      iIrq[b] = 1'b0; tick();
   endtask

   task automatic io_write(input logic [15:0] a, input logic [7:0] d);
      iAddr = a; iData = d; iIoWr = 1'b1; tick();
      iIoWr = 1'b0; tick();
   endtask

   task automatic io_read(input logic [15:0] a, output logic [7:0] v);
      iAddr = a; iIoRd = 1'b1; tick();
      v = oData;
      iIoRd = 1'b0; tick();
   endtask

   task automatic inta(output logic [7:0] v);
      iIntAck = 1'b1; tick();
      iIntAck = 1'b0; tick();
      iIntAck = 1'b1; tick();
      v = oData;
      check("inta_sel", {7'd0, oSel}, 8'h01);
      tick();
      iIntAck = 1'b0; tick();
   endtask

   initial begin
      logic [7:0] v;
      bit wr_active;
      wr_active = 1'b0;

      // reset
      iRst = 1'b0; tick(); tick();
      check("rst_int", {7'd0, oInt}, 8'h00);
      check("rst_sel", {7'd0, oSel}, 8'h00);
      check("rst_data", oData, 8'h00);
      iRst = 1'b1; tick();

      // masked request, then unmask channel 3
      pulse(3); idle(3);
      check("masked_int", {7'd0, oInt}, 8'h00);
      io_write(16'h0021, 8'hF7);
      check("unmask_int", {7'd0, oInt}, 8'h01);
      inta(v); check("vec_ch3", v, 8'h0B);
      io_write(16'h0020, 8'h20);
      io_write(16'h0021, 8'h00);

      // simultaneous 5 and 2
      iIrq = 8'h24; tick(); iIrq = 8'h00; tick(); idle(2);
      inta(v); check("vec_ch2", v, 8'h0A);
      io_read(16'h0020, v); check("isr_04", v, 8'h04);
      check("model_isr_04", m_isr, 8'h04);
      check("ch5_blocked", {7'd0, oInt}, 8'h00);

      // nested: 6 blocked, 1 preempts
      pulse(6); idle(2);
      check("ch6_blocked", {7'd0, oInt}, 8'h00);
      pulse(1); idle(1);
      check("ch1_int", {7'd0, oInt}, 8'h01);
      inta(v); check("vec_ch1", v, 8'h09);
      io_read(16'h0020, v); check("isr_06", v, 8'h06);
      io_write(16'h0020, 8'h20);
      io_write(16'h0020, 8'h20); idle(1);
      check("ch5_int", {7'd0, oInt}, 8'h01);
      inta(v); check("vec_ch5", v, 8'h0D);
      io_write(16'h0020, 8'h20); idle(1);
      inta(v); check("vec_ch6", v, 8'h0E);
      io_write(16'h0020, 8'h20); idle(1);

      // level channel 4 withdrawn before INTA -> spurious
      iIrq[4] = 1'b1; tick(); tick();
      check("lvl_int", {7'd0, oInt}, 8'h01);
      iIrq[4] = 1'b0; tick(); tick();
      check("lvl_drop", {7'd0, oInt}, 8'h00);
      inta(v); check("vec_spur", v, 8'h0F);
      io_read(16'h0020, v); check("isr_spur", v, 8'h00);

      // specific EOI and empty non-specific EOI
      pulse(3); idle(1); inta(v); check("vec_ch3b", v, 8'h0B);
      pulse(2); idle(1); inta(v); check("vec_ch2b", v, 8'h0A);
      io_read(16'h0020, v); check("isr_0c", v, 8'h0C);
      io_write(16'h0020, 8'h63);
      io_read(16'h0020, v); check("isr_after_63", v, 8'h04);
      io_write(16'h0020, 8'h20);
      io_write(16'h0020, 8'h20);
      io_read(16'h0020, v); check("isr_empty", v, 8'h00);
      check("model_isr_empty", m_isr, 8'h00);

      // reset during WAIT2
      pulse(0); idle(1);
      iIntAck = 1'b1; tick();
      iIntAck = 1'b0; tick();
      iRst = 1'b0; tick();
      check("rst_w2_sel", {7'd0, oSel}, 8'h00);
      check("rst_w2_int", {7'd0, oInt}, 8'h00);
      iRst = 1'b1; tick();
      io_read(16'h0020, v); check("rst_w2_isr", v, 8'h00);
      io_read(16'h0021, v); check("rst_w2_imr", v, 8'hFF);
      inta(v); check("vec_after_rst", v, 8'h0F);

      // randomized traffic
      io_write(16'h0021, 8'h00);
      for (int c = 0; c < 4000; c++) begin
         iRst = ($urandom_range(0, 599) != 0);
         if ($urandom_range(0, 3) == 0) iIrq = iIrq ^ (8'd1 << $urandom_range(0, 7));
         if ($urandom_range(0, 5) == 0) iIntAck = ~iIntAck;
         if (wr_active) begin
            if ($urandom_range(0, 1) == 0) begin iIoWr = 1'b0; wr_active = 1'b0; end
         end else if ($urandom_range(0, 11) == 0) begin
            case ($urandom_range(0, 3))
               0: iAddr = 16'h0020;
               1: iAddr = 16'h0020;
               2: iAddr = 16'h0021;
               default: iAddr = 16'h0022;
            endcase
            case ($urandom_range(0, 3))
               0: iData = 8'h20;
               1: iData = 8'h60 | 8'($urandom_range(0, 7));
               2: iData = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
               default: iData = 8'($urandom_range(0, 255));
            endcase
            iIoWr = 1'b1; wr_active = 1'b1;
         end
         if ($urandom_range(0, 7) == 0) iIoRd = ~iIoRd;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
